// File: rtl/req_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | req_pkg : shared types and helpers for the request collector       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package req_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_one_enc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lowest_one_enc : index of the lowest set bit (0 when none is set)  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lowest_one_enc
  import req_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | req_collector : pending-request register served lowest-index first |
// | over valid/ready. Option macro: REQ_COLLECTOR_B2B_EN (b2b grants). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module req_collector
  import req_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] set_i,
  input  logic             clr_all_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending_o,
  output logic [IDX_W:0]   count_o
);

  state_t           state_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic [IDX_W-1:0] idx_q;

  logic             hs;
  logic [WIDTH-1:0] pop_mask;
  logic [WIDTH-1:0] pend_pop;
  logic [WIDTH-1:0] enc_vec;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;

  assign hs       = (state_q == HOLD) && out_ready;
  assign pop_mask = hs ? ({{(WIDTH-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign pend_pop = pending_q & ~pop_mask;
  // A same-cycle set of the popped bit survives because set_i is ORed last.
  assign pending_d = clr_all_i ? '0 : (pend_pop | set_i);

`ifdef REQ_COLLECTOR_B2B_EN
  assign enc_vec = (state_q == HOLD) ? pend_pop : pending_q;
`else
  assign enc_vec = pending_q;
`endif

  lowest_one_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (enc_vec),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (clr_all_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (enc_found) begin
              idx_q   <= enc_idx;
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (hs) begin
`ifdef REQ_COLLECTOR_B2B_EN
              if (enc_found) begin
                idx_q   <= enc_idx;
                state_q <= HOLD;
              end else begin
                state_q <= IDLE;
              end
`else
              state_q <= IDLE;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_idx   = idx_q;
  assign pending_o = pending_q;
  assign count_o   = (IDX_W+1)'(popcount(32'(pending_q)));

endmodule
`default_nettype wire
